// File: rtl/matrix_cmd_issuer.sv
// Sequences GL matrix commands into matrix stack controller pulses and rows.
// Define MATRIX_DEPTH_CHECK_EN to block stack overflow/underflow per mode.
module matrix_cmd_issuer #(
    parameter int MV_DEPTH = 32,
    parameter int PJ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_mode,
    input  logic [127:0] cmd_data,
    input  logic         err_clr,
    output logic         matrix_mode,
    output logic         load_en,
    output logic         load_id_en,
    output logic         pop_en,
    output logic         write_en,
    output logic [127:0] data_in,
    output logic [127:0] write_in_0,
    output logic [127:0] write_in_1,
    output logic [127:0] write_in_2,
    output logic [127:0] write_in_3,
    output logic         err_stack,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_LD0, S_LD1, S_LD2, S_LD3, S_WR, S_PULSE
    } state_t;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_SET_MODE = 3'd1;
    localparam logic [2:0] OP_LOAD_ID  = 3'd2;
    localparam logic [2:0] OP_LOAD     = 3'd3;
    localparam logic [2:0] OP_POP      = 3'd4;
    localparam logic [2:0] OP_WRITE    = 3'd5;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [2:0]   op_q, op_d;
    logic         mode_q, mode_d;
    logic         err_q, err_d;
    logic         live_q;
    logic [127:0] rb_q [4];
    logic [127:0] din_q, din_d;
    logic [127:0] wr_q [4];
    logic [127:0] wr_d [4];
    logic         rb_we;
    logic         err_set;
    logic         hs;
    logic         at_cap;
    logic         at_floor;

    assign cmd_ready = live_q && (state_q == S_IDLE || state_q == S_COLLECT);
    assign hs        = cmd_valid && cmd_ready;

`ifdef MATRIX_DEPTH_CHECK_EN
    logic [5:0] depth_q [2];
    logic       inc, dec;

    assign at_cap   = depth_q[mode_q] == (mode_q ? 6'(PJ_DEPTH) : 6'(MV_DEPTH));
    assign at_floor = depth_q[mode_q] == 6'd1;
    assign inc = hs && state_q == S_COLLECT && cnt_q == 2'd3
              && op_q == OP_LOAD && !at_cap;
    assign dec = hs && state_q == S_IDLE && cmd_op == OP_POP && !at_floor;

    // Depth starts at 1: the resident initial matrix of each stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q[0] <= 6'd1;
            depth_q[1] <= 6'd1;
        end else if (inc) begin
            depth_q[mode_q] <= depth_q[mode_q] + 6'd1;
        end else if (dec) begin
            depth_q[mode_q] <= depth_q[mode_q] - 6'd1;
        end
    end
`else
    assign at_cap   = 1'b0;
    assign at_floor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mode_d  = mode_q;
        din_d   = din_q;
        wr_d    = wr_q;
        rb_we   = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    op_d = cmd_op;
                    unique case (cmd_op)
                        OP_NOP: ;
                        OP_SET_MODE: mode_d = cmd_mode;
                        OP_LOAD_ID: state_d = S_PULSE;
                        OP_POP: begin
                            if (at_floor) err_set = 1'b1;
                            else          state_d = S_PULSE;
                        end
                        OP_LOAD, OP_WRITE: begin
                            rb_we   = 1'b1;
                            cnt_d   = 2'd1;
                            state_d = S_COLLECT;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            S_COLLECT: begin
                if (hs) begin
                    rb_we = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (op_q == OP_WRITE) begin
                            state_d = S_WR;
                            wr_d[0] = rb_q[0];
                            wr_d[1] = rb_q[1];
                            wr_d[2] = rb_q[2];
                            wr_d[3] = cmd_data;
                        end else if (at_cap) begin
                            err_set = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_LD0;
                            din_d   = rb_q[0];
                        end
                    end
                end
            end
            S_LD0: begin
                state_d = S_LD1;
                din_d   = rb_q[1];
            end
            S_LD1: begin
                state_d = S_LD2;
                din_d   = rb_q[2];
            end
            S_LD2: begin
                state_d = S_LD3;
                din_d   = rb_q[3];
            end
            S_LD3, S_WR, S_PULSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Set wins over clear so a same-cycle error is never lost.
    assign err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            op_q    <= OP_NOP;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
            din_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                rb_q[i] <= '0;
                wr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
            din_q   <= din_d;
            wr_q    <= wr_d;
            if (rb_we) rb_q[cnt_q] <= cmd_data;
        end
    end

    assign matrix_mode = mode_q;
    assign err_stack   = err_q;
    assign busy        = state_q != S_IDLE;
    assign load_en     = state_q == S_LD0;
    assign write_en    = state_q == S_WR;
    assign load_id_en  = state_q == S_PULSE && op_q == OP_LOAD_ID;
    assign pop_en      = state_q == S_PULSE && op_q == OP_POP;
    assign data_in     = din_q;
    assign write_in_0  = wr_q[0];
    assign write_in_1  = wr_q[1];
    assign write_in_2  = wr_q[2];
    assign write_in_3  = wr_q[3];

endmodule

// File: tb/tb_matrix_cmd_issuer.sv
// Scoreboard bench for matrix_cmd_issuer: expected pulses are queued when
// commands are driven and popped as the stack-side outputs appear.
module tb_matrix_cmd_issuer;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_SET_MODE = 3'd1;
    localparam logic [2:0] OP_LOAD_ID  = 3'd2;
    localparam logic [2:0] OP_LOAD     = 3'd3;
    localparam logic [2:0] OP_POP      = 3'd4;
    localparam logic [2:0] OP_WRITE    = 3'd5;

`ifdef MATRIX_DEPTH_CHECK_EN
    localparam bit DCHK = 1'b1;
`else
    localparam bit DCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic         cmd_mode = 1'b0;
    logic [127:0] cmd_data = '0;
    logic         err_clr = 1'b0;
    logic         matrix_mode;
    logic         load_en, load_id_en, pop_en, write_en;
    logic [127:0] data_in;
    logic [127:0] write_in_0, write_in_1, write_in_2, write_in_3;
    logic         err_stack;
    logic         busy;

    always #5 clk = ~clk;

    matrix_cmd_issuer #(.MV_DEPTH(32), .PJ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
        .err_clr(err_clr), .matrix_mode(matrix_mode),
        .load_en(load_en), .load_id_en(load_id_en),
        .pop_en(pop_en), .write_en(write_en),
        .data_in(data_in),
        .write_in_0(write_in_0), .write_in_1(write_in_1),
        .write_in_2(write_in_2), .write_in_3(write_in_3),
        .err_stack(err_stack), .busy(busy)
    );

    typedef enum logic [2:0] {K_LD0, K_ROW, K_WR, K_LID, K_POP} kind_e;
    typedef struct {
        kind_e        k;
        logic         mode;
        logic [511:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   follow = 0;
    int   acc_cyc = 0;
    int   ld0_cyc = -1;
    int   lid_cyc = -1;
    int   pop_cyc = -1;
    logic cur_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input kind_e k, input logic [511:0] d);
        exp_t e;
        e.k = k;
        e.mode = cur_mode;
        e.d = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        int   np;
        exp_t e;
        np = int'(load_en) + int'(load_id_en) + int'(pop_en) + int'(write_en);
        if (rst_n && (np > 0 || follow > 0)) begin
            if (np > 1) chk("pulse_onehot", 512'(np), 512'(1));
            if (sb.size() == 0) begin
                chk("spurious_out", {load_en, load_id_en, pop_en, write_en}, 4'b0);
            end else begin
                e = sb.pop_front();
                chk("out_mode", matrix_mode, e.mode);
                if (follow > 0) begin
                    chk("row_kind", e.k, K_ROW);
                    chk("row_quiet", 512'(np), 512'(0));
                    chk("row_data", data_in, e.d);
                    follow--;
                end else if (load_en) begin
                    chk("ld0_kind", e.k, K_LD0);
                    chk("ld0_data", data_in, e.d);
                    ld0_cyc = cyc;
                    follow = 3;
                end else if (write_en) begin
                    chk("wr_kind", e.k, K_WR);
                    chk("wr_rows", {write_in_3, write_in_2, write_in_1, write_in_0}, e.d);
                end else if (load_id_en) begin
                    chk("lid_kind", e.k, K_LID);
                    lid_cyc = cyc;
                end else begin
                    chk("pop_kind", e.k, K_POP);
                    pop_cyc = cyc;
                end
            end
        end
    end

    task automatic beat(input logic [2:0] op, input logic m, input logic [127:0] d);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mode = m;
        cmd_data = d;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!cmd_ready) chk("hs_timeout", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int gap, input bit issue);
        logic [127:0] r [4];
        for (int i = 0; i < 4; i++) r[i] = rnd();
        if (issue) begin
            push(K_LD0, 512'(r[0]));
            for (int i = 1; i < 4; i++) push(K_ROW, 512'(r[i]));
        end
        beat(OP_LOAD, 1'b0, r[0]);
        for (int i = 1; i < 4; i++) begin
            if (gap > 0) idle(gap);
            beat(3'($urandom), 1'($urandom), r[i]);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic ready_low(input string tag, input int exp);
        int n;
        n = 0;
        cmd_valid = 1'b0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 512'(n), 512'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_ctl"}, {cmd_ready, matrix_mode, load_en, load_id_en,
                            pop_en, write_en, err_stack, busy}, 8'b0);
        chk({tag, "_din"}, data_in, 512'(0));
        chk({tag, "_wr"}, {write_in_3, write_in_2, write_in_1, write_in_0}, 512'(0));
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_clk", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rdy_after_clk", cmd_ready, 1'b1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_cleared", err_stack, 1'b0);
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] w [4];
        int a_lid;
        #2;
        rst_checks("reset");
        repeat (2) @(posedge clk);
        #1;
        release_rst();

        beat(OP_SET_MODE, 1'b1, '0);
        cmd_valid = 1'b0;
        cur_mode = 1'b1;
        chk("setmode_mode", matrix_mode, 1'b1);
        chk("setmode_rdy", cmd_ready, 1'b1);

        do_load(1, 1'b1);
        ready_low("load_rdy_low", 4);
        chk("ld0_latency", 512'(ld0_cyc - acc_cyc), 512'(0));

        for (int i = 0; i < 4; i++) w[i] = 128'(i + 1);
        push(K_WR, {w[3], w[2], w[1], w[0]});
        for (int i = 0; i < 4; i++) beat(i == 0 ? OP_WRITE : 3'($urandom), 1'b0, w[i]);
        ready_low("wr_rdy_low", 1);

        push(K_LID, '0);
        push(K_POP, '0);
        beat(OP_LOAD_ID, 1'b0, '0);
        a_lid = acc_cyc;
        beat(OP_POP, 1'b0, '0);
        idle(4);
        chk("lid_latency", 512'(lid_cyc - a_lid), 512'(0));
        chk("pop_after_lid", 512'(pop_cyc - lid_cyc), 512'(2));

        do_load(0, 1'b1);
        ready_low("load2_rdy_low", 4);
        do_load(0, !DCHK);
        ready_low("load3_rdy_low", DCHK ? 0 : 4);
        chk("err_overflow", err_stack, DCHK);
        clear_err();
        push(K_POP, '0);
        beat(OP_POP, 1'b0, '0);
        ready_low("pop1_rdy_low", 1);
        chk("err_pop1", err_stack, 1'b0);
        if (!DCHK) push(K_POP, '0);
        beat(OP_POP, 1'b0, '0);
        ready_low("pop2_rdy_low", DCHK ? 0 : 1);
        chk("err_underflow", err_stack, DCHK);
        clear_err();

        do_load(0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        follow = 0;
        cur_mode = 1'b0;
        rst_checks("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        release_rst();
        idle(8);

        beat(OP_SET_MODE, 1'b1, '0);
        cur_mode = 1'b1;
        if (!DCHK) push(K_POP, '0);
        beat(OP_POP, 1'b0, '0);
        ready_low("pop_after_rst", DCHK ? 0 : 1);
        chk("err_depth_reset", err_stack, DCHK);
        clear_err();

        beat(OP_NOP, 1'b0, '0);
        cmd_valid = 1'b0;
        chk("nop_err", err_stack, 1'b0);
        chk("nop_busy", busy, 1'b0);
        err_clr = 1'b1;
        beat(3'd7, 1'b0, '0);
        err_clr = 1'b0;
        cmd_valid = 1'b0;
        chk("illegal_err", err_stack, 1'b1);
        chk("illegal_rdy", cmd_ready, 1'b1);
        chk("illegal_busy", busy, 1'b0);
        clear_err();

        idle(6);
        chk("sb_drained", 512'(sb.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
